p2s_8_1: RTL and testbench

//  Transmit-lane parallel-to-serial stage. Sits directly downstream of the 32-8b stage (m32_8):

---
 rtl/p2s_8_1.sv | 119 +++++++++++
 tb/tb_p2s_8_1.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/p2s_8_1.sv
// rtl/p2s_8_1.sv - transmit-lane 8:1 serializer: COM sync burst, then data/IDL symbols, MSB first
// Optional scrambling of data bytes with a 16-bit LFSR is built when P2S_SCRAMBLE_EN is defined.
module p2s_8_1 #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  IDL_SYM    = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       valid_out,
  output logic       byte_ack,
  output logic       sync_done
);

  localparam int CW = $clog2(SYNC_COUNT + 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_COUNT - 1);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg, shift_n;
  logic [CW-1:0]   sync_cnt, sync_cnt_n;
  logic            load;
  logic            ack_n;
  logic            valid_out_n;
  logic [7:0]      data_sym;

  assign load      = (bit_cnt == 3'd7);
  assign sync_done = (state == ST_ACTIVE);

`ifdef P2S_SCRAMBLE_EN
  logic [15:0] lfsr, lfsr_n, lfsr_adv;
  logic [7:0]  scr_mask;

  // Eight LFSR steps unrolled so a whole byte's keystream is ready at the load point.
  always_comb begin
    lfsr_adv = lfsr;
    scr_mask = '0;
    for (int i = 7; i >= 0; i--) begin
      scr_mask[i] = lfsr_adv[15];
      lfsr_adv    = {lfsr_adv[14:0], lfsr_adv[15] ^ lfsr_adv[4] ^ lfsr_adv[3] ^ lfsr_adv[2]};
    end
  end

  assign data_sym = data_in ^ scr_mask;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) lfsr <= 16'hFFFF;
    else       lfsr <= lfsr_n;
  end
`else
  assign data_sym = data_in;
`endif

  always_comb begin
    state_n     = state;
    sync_cnt_n  = sync_cnt;
    shift_n     = {shift_reg[6:0], 1'b0};
    ack_n       = 1'b0;
    valid_out_n = valid_out;
`ifdef P2S_SCRAMBLE_EN
    lfsr_n      = lfsr;
`endif
    if (load) begin
      valid_out_n = 1'b1;
      case (state)
        ST_SYNC: begin
          shift_n    = COM_SYM;
          sync_cnt_n = sync_cnt + CW'(1);
`ifdef P2S_SCRAMBLE_EN
          lfsr_n     = 16'hFFFF;
`endif
          if (sync_cnt == SYNC_LAST) state_n = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (valid_in) begin
            shift_n = data_sym;
            ack_n   = 1'b1;
`ifdef P2S_SCRAMBLE_EN
            lfsr_n  = lfsr_adv;
`endif
          end else begin
            shift_n = IDL_SYM;
          end
        end
        default: state_n = ST_SYNC;
      endcase
    end
  end

  // data_out always mirrors the MSB of the register's next value, so a load emits bit 7 directly.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= ST_SYNC;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      sync_cnt  <= '0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
      byte_ack  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt + 3'd1;
      shift_reg <= shift_n;
      sync_cnt  <= sync_cnt_n;
      data_out  <= shift_n[7];
      valid_out <= valid_out_n;
      byte_ack  <= ack_n;
    end
  end

endmodule

// File: tb/tb_p2s_8_1.sv
// tb/tb_p2s_8_1.sv - scoreboard bench for p2s_8_1 (expectations follow P2S_SCRAMBLE_EN when defined)
module tb_p2s_8_1;

  localparam int         SYNC_COUNT = 4;
  localparam logic [7:0] COM_SYM    = 8'hBC;
  localparam logic [7:0] IDL_SYM    = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out, valid_out, byte_ack, sync_done;

  p2s_8_1 dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .byte_ack (byte_ack),
    .sync_done(sync_done)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic d;
    logic ack;
    logic sd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   slot_idx = 0;
  int   pre_cnt  = 0;
  bit   seen_valid = 1'b0;
  bit   mon_en     = 1'b1;
  logic [15:0] lfsr_m = 16'hFFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next eight keystream bits, MSB first, from the x^16+x^5+x^4+x^3+1 sequence.
  function automatic logic [7:0] keystream8();
    logic [7:0] m;
    logic       fb;
    m = '0;
    for (int i = 7; i >= 0; i--) begin
      m[i]   = lfsr_m[15];
      fb     = lfsr_m[15] ^ lfsr_m[4] ^ lfsr_m[3] ^ lfsr_m[2];
      lfsr_m = {lfsr_m[14:0], fb};
    end
    return m;
  endfunction

  // Expected symbol stream: SYNC_COUNT COMs after reset, then data when valid else IDL.
  task automatic push_expect(input bit v, input logic [7:0] d);
    logic [7:0] sym;
    bit         ack, sd;
    if (slot_idx < SYNC_COUNT) begin
      sym    = COM_SYM;
      ack    = 1'b0;
      sd     = (slot_idx == SYNC_COUNT - 1);
      lfsr_m = 16'hFFFF;
    end else if (v) begin
      sym = d;
`ifdef P2S_SCRAMBLE_EN
      sym = d ^ keystream8();
`endif
      ack = 1'b1;
      sd  = 1'b1;
    end else begin
      sym = IDL_SYM;
      ack = 1'b0;
      sd  = 1'b1;
    end
    for (int i = 7; i >= 0; i--)
      exp_q.push_back('{d: sym[i], ack: (i == 7) ? ack : 1'b0, sd: sd});
    slot_idx++;
  endtask

  // One byte period: valid_in is jittered off the load point, real values set just before it.
  task automatic run_slot(input bit v, input logic [7:0] d);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk_32f);
      #1;
      if (c < 7) valid_in = 1'($urandom_range(0, 1));
    end
    valid_in = v;
    data_in  = d;
    push_expect(v, d);
    @(posedge clk_32f);
    #1;
  endtask

  task automatic do_reset_release();
    @(negedge clk_32f);
    #2;
    reset = 1'b0;
  endtask

  always @(negedge clk_32f) begin
    exp_t e;
    if (reset) begin
      pre_cnt    = 0;
      seen_valid = 1'b0;
    end else if (mon_en) begin
      if (!valid_out) begin
        if (seen_valid) chk("valid_out_hold", 32'(valid_out), 32'd1);
        else begin
          pre_cnt++;
          chk("pre_data_out", 32'(data_out), 32'd0);
          chk("pre_byte_ack", 32'(byte_ack), 32'd0);
          chk("pre_sync_done", 32'(sync_done), 32'd0);
        end
      end else begin
        // release lands mid low-phase, so 7 sampled edges cover the 8 idle cycles
        if (!seen_valid) begin
          seen_valid = 1'b1;
          chk("pre_len", 32'(pre_cnt), 32'd7);
        end
        if (exp_q.size() == 0) chk("underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("byte_ack", 32'(byte_ack), 32'(e.ack));
          chk("sync_done", 32'(sync_done), 32'(e.sd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq [4];
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78;

    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_byte_ack", 32'(byte_ack), 32'd0);
    chk("rst_sync_done", 32'(sync_done), 32'd0);
    do_reset_release();

    for (int i = 0; i < SYNC_COUNT + 2; i++) run_slot(1'b0, 8'h00);
    run_slot(1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) run_slot(1'b1, seq[i]);
    run_slot(1'b0, 8'h00);
    for (int i = 0; i < 40; i++) run_slot(1'($urandom_range(0, 1)), 8'($urandom));

    // Asynchronous reset in the middle of a data byte
    run_slot(1'b1, 8'hC3);
    repeat (3) @(posedge clk_32f);
    #2;
    reset = 1'b1;
    exp_q.delete();
    slot_idx = 0;
    lfsr_m   = 16'hFFFF;
    #1;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_byte_ack", 32'(byte_ack), 32'd0);
    chk("midrst_sync_done", 32'(sync_done), 32'd0);
    do_reset_release();

    // valid_in held high through SYNC, then a zero-data stream
    for (int i = 0; i < SYNC_COUNT; i++) run_slot(1'b1, 8'($urandom));
    for (int i = 0; i < 6; i++) run_slot(1'b1, 8'h00);
    run_slot(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) run_slot(1'($urandom_range(0, 1)), 8'($urandom));
    valid_in = 1'b0;

    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 40) begin
        @(negedge clk_32f);
        #1;
        budget++;
      end
      mon_en = 1'b0;
      chk("drain", 32'(exp_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
